// File: rtl/uart_tx_fifo_pkg.sv
// Shared types and defaults for the UART transmit buffer.
package uart_tx_fifo_pkg;

    // Issue sequencer states; encodings are visible on the debug state port.
    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ISSUE     = 2'd1,
        ST_WAIT_BUSY = 2'd2,
        ST_WAIT_DONE = 2'd3
    } tx_state_e;

    localparam int DEF_DATA_WIDTH   = 8;
    localparam int DEF_DEPTH_LOG2   = 4;
    localparam int DEF_BUSY_TIMEOUT = 4;

endpackage

// File: rtl/uart_tx_fifo_tx_byte_fifo.sv
// Byte FIFO: storage, pointers, occupancy count, full/empty and sticky overflow.
// A write while full is dropped even if a pop happens in the same clk.
module tx_byte_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] head,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  overflow,
    input  logic                  ovf_clr
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   FULL_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [DEPTH_LOG2:0]   CNT_ONE  = {{DEPTH_LOG2{1'b0}}, 1'b1};
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [DEPTH_LOG2:0]   count_q;
    logic                  push_ok;
    logic                  pop_ok;

    assign full    = (count_q == FULL_CNT);
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign head    = mem[rd_ptr];
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    // Storage write; contents are not reset, only the pointers/count are.
    always_ff @(posedge clk) begin
        if (rst && push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers, occupancy and sticky overflow (set wins over clear).
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count_q  <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop_ok)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + CNT_ONE;
                2'b01:   count_q <= count_q - CNT_ONE;
                default: count_q <= count_q;
            endcase
            if (push && full) begin
                overflow <= 1'b1;
            end else if (ovf_clr) begin
                overflow <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmit buffer: FIFO plus a sequencer that issues one byte per frame
// to the transmitter, re-pulsing send if ready never drops.
// Handshake: a byte is issued by a one-clk tx_send pulse with tx_data stable;
// the transmitter acknowledges by dropping tx_ready and signals frame end by
// raising it again. tx_data only changes on a pop in IDLE.
module uart_tx_fifo
    import uart_tx_fifo_pkg::*;
#(
    parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int DEPTH_LOG2   = DEF_DEPTH_LOG2,
    parameter int BUSY_TIMEOUT = DEF_BUSY_TIMEOUT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  overflow,
    input  logic                  ovf_clr,
    input  logic                  tx_ready,
    output logic                  tx_send,
    output logic [DATA_WIDTH-1:0] tx_data,
    output logic                  busy,
    output tx_state_e             state
);
    localparam int TMR_W = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(BUSY_TIMEOUT - 1);
    localparam logic [TMR_W-1:0] TMR_ONE  = TMR_W'(1);

    tx_state_e             state_q, state_n;
    logic [TMR_W-1:0]      tmr_q, tmr_n;
    logic [DATA_WIDTH-1:0] data_q, data_n;
    logic                  send_q, send_n;
    logic                  pop;
    logic [DATA_WIDTH-1:0] head;

    tx_byte_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (wr_en),
        .push_data (wr_data),
        .pop       (pop),
        .head      (head),
        .full      (full),
        .empty     (empty),
        .count     (count),
        .overflow  (overflow),
        .ovf_clr   (ovf_clr)
    );

    assign tx_send = send_q;
    assign tx_data = data_q;
    assign state   = state_q;
    assign busy    = (state_q != ST_IDLE) || !empty;

    // Sequencer registers: state, busy timeout, presented byte and send pulse.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            tmr_q   <= '0;
            data_q  <= '0;
            send_q  <= 1'b0;
        end else begin
            state_q <= state_n;
            tmr_q   <= tmr_n;
            data_q  <= data_n;
            send_q  <= send_n;
        end
    end

    // Next-state logic: pop in IDLE, one-clk pulse, wait for ack, wait for frame end.
    always_comb begin
        state_n = state_q;
        tmr_n   = tmr_q;
        data_n  = data_q;
        send_n  = 1'b0;
        pop     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!empty && tx_ready) begin
                    pop     = 1'b1;
                    data_n  = head;
                    send_n  = 1'b1;
                    tmr_n   = '0;
                    state_n = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                state_n = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                if (!tx_ready) begin
                    state_n = ST_WAIT_DONE;
                end else if (tmr_q == TMR_LAST) begin
                    // Transmitter missed the pulse; send the same byte again.
                    send_n  = 1'b1;
                    tmr_n   = '0;
                    state_n = ST_ISSUE;
                end else begin
                    tmr_n = tmr_q + TMR_ONE;
                end
            end
            ST_WAIT_DONE: begin
                if (tx_ready) state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
    end

endmodule
